// File: rtl/alu_ctrl_muldiv.sv
// EX-stage ALU decoder plus an iterative RV32M multiply/divide engine.
// Define RV_M_EXT_EN to build the mul/div engine; otherwise its outputs are 0.
module alu_ctrl_muldiv #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid_in,
  input  logic            flush,
  input  logic [1:0]      ALUOp,
  input  logic [2:0]      funct3,
  input  logic            funct7_5,
  input  logic            funct7_0,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic [3:0]      Operation,
  output logic            stall,
  output logic            md_valid,
  output logic [XLEN-1:0] md_result
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SRL  = 4'b0100;
  localparam logic [3:0] OP_SRA  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLL  = 4'b0111;
  localparam logic [3:0] OP_SLT  = 4'b1000;
  localparam logic [3:0] OP_SLTU = 4'b1001;

  // ALU operation decode from ALUOp/funct only
  always_comb begin
    Operation = OP_ADD;
    unique case (ALUOp)
      2'b00: Operation = OP_ADD;
      2'b01: begin
        unique case (funct3[2:1])
          2'b10:   Operation = OP_SLT;
          2'b11:   Operation = OP_SLTU;
          default: Operation = OP_SUB;
        endcase
      end
      default: begin
        unique case (funct3)
          3'b000:  Operation = (funct7_5 && ALUOp == 2'b10) ? OP_SUB : OP_ADD;
          3'b001:  Operation = OP_SLL;
          3'b010:  Operation = OP_SLT;
          3'b011:  Operation = OP_SLTU;
          3'b100:  Operation = OP_XOR;
          3'b101:  Operation = funct7_5 ? OP_SRA : OP_SRL;
          3'b110:  Operation = OP_OR;
          default: Operation = OP_AND;
        endcase
      end
    endcase
  end

`ifdef RV_M_EXT_EN
  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MINV = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   count;
  logic [2:0]      fn;
  logic            neg, neg_r;
  logic [XLEN-1:0] hi, lo, dvs;

  logic            start, a_sgn, b_sgn, sa, sb;
  logic            div_zero, div_ovf, special;
  logic [XLEN-1:0] abs_a, abs_b, spec_res;

  assign start = valid_in & (ALUOp == 2'b10) & funct7_0
               & (state == IDLE) & ~flush;

  assign a_sgn = funct3[2] ? ~funct3[0] : (funct3[1:0] != 2'b11);
  assign b_sgn = funct3[2] ? ~funct3[0] : ~funct3[1];
  assign sa    = a_sgn & op_a[XLEN-1];
  assign sb    = b_sgn & op_b[XLEN-1];
  assign abs_a = sa ? -op_a : op_a;
  assign abs_b = sb ? -op_b : op_b;

  assign div_zero = funct3[2] & (op_b == '0);
  assign div_ovf  = funct3[2] & ~funct3[0] & (op_a == MINV) & (&op_b);
  assign special  = div_zero | div_ovf;
  assign spec_res = div_zero ? (funct3[1] ? op_a : '1)
                             : (funct3[1] ? '0 : op_a);

  logic [XLEN:0]     madd, msum, r_sh, diff;
  logic [XLEN-1:0]   nx_hi, nx_lo, quo, rem, fin;
  logic [2*XLEN-1:0] prod, prod_f;
  logic              ge;

  // One shift-add or restoring-divide step, plus final sign fix
  always_comb begin
    madd   = lo[0] ? {1'b0, dvs} : '0;
    msum   = {1'b0, hi} + madd;
    r_sh   = {hi, lo[XLEN-1]};
    diff   = r_sh - {1'b0, dvs};
    ge     = ~diff[XLEN];
    nx_hi  = fn[2] ? (ge ? diff[XLEN-1:0] : r_sh[XLEN-1:0])
                   : msum[XLEN:1];
    nx_lo  = fn[2] ? {lo[XLEN-2:0], ge}
                   : {msum[0], lo[XLEN-1:1]};
    prod   = {nx_hi, nx_lo};
    prod_f = neg ? -prod : prod;
    quo    = neg ? -nx_lo : nx_lo;
    rem    = neg_r ? -nx_hi : nx_hi;
    fin    = fn[2] ? (fn[1] ? rem : quo)
                   : ((fn[1:0] == 2'b00) ? prod_f[XLEN-1:0]
                                         : prod_f[2*XLEN-1:XLEN]);
  end

  // Next-state logic; flush always returns to IDLE
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = special ? DONE : BUSY;
      BUSY:    if (count == LAST) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (flush) state_nx = IDLE;
  end

  // State, operand latches, iteration registers and result
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      count     <= '0;
      fn        <= '0;
      neg       <= 1'b0;
      neg_r     <= 1'b0;
      hi        <= '0;
      lo        <= '0;
      dvs       <= '0;
      md_result <= '0;
    end else begin
      state <= state_nx;
      if (start) begin
        fn    <= funct3;
        neg   <= sa ^ sb;
        neg_r <= sa;
        hi    <= '0;
        lo    <= funct3[2] ? abs_a : abs_b;
        dvs   <= funct3[2] ? abs_b : abs_a;
        count <= '0;
        if (special) md_result <= spec_res;
      end else if (state == BUSY) begin
        hi    <= nx_hi;
        lo    <= nx_lo;
        count <= count + 1'b1;
        if (count == LAST && !flush) md_result <= fin;
      end
    end
  end

  assign stall    = start | (state == BUSY);
  assign md_valid = (state == DONE);
`else
  logic unused_md;
  assign unused_md = ^{clk, reset, valid_in, flush, funct7_0, op_a, op_b};
  assign stall     = 1'b0;
  assign md_valid  = 1'b0;
  assign md_result = '0;
`endif

endmodule

// File: tb/tb_alu_ctrl_muldiv.sv
// Bench for alu_ctrl_muldiv: decode table plus mul/div scoreboard.
// Mul/div sequences run only when RV_M_EXT_EN is defined.
module tb_alu_ctrl_muldiv;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            reset, valid_in, flush;
  logic [1:0]      ALUOp;
  logic [2:0]      funct3;
  logic            funct7_5, funct7_0;
  logic [XLEN-1:0] op_a, op_b;
  logic [3:0]      Operation;
  logic            stall, md_valid;
  logic [XLEN-1:0] md_result;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [XLEN-1:0] exp_q[$];

  alu_ctrl_muldiv #(.XLEN(XLEN)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .flush(flush),
    .ALUOp(ALUOp), .funct3(funct3), .funct7_5(funct7_5),
    .funct7_0(funct7_0), .op_a(op_a), .op_b(op_b),
    .Operation(Operation), .stall(stall), .md_valid(md_valid),
    .md_result(md_result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // scoreboard: every md_valid pops one expected result
  always @(negedge clk) begin
    if (md_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected md_valid: got 1 want 0");
      end else begin
        check("md_result", md_result, exp_q.pop_front());
      end
    end
  end

  typedef struct {
    logic [1:0] aop;
    logic [2:0] f3;
    logic       f75;
    logic [3:0] op;
  } dec_t;

  dec_t tbl[32];

  task automatic run_md(input string name, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int lat,
                        output int vcyc);
    bit st_ok;
    bit got;
    int k;
    @(posedge clk); #1;
    valid_in = 1; ALUOp = 2'b10; funct7_0 = 1; funct7_5 = 0;
    funct3 = f3; op_a = a; op_b = b;
    exp_q.push_back(exp);
    @(negedge clk);
    st_ok = (stall === 1'b1);
    @(posedge clk); #1;
    valid_in = 0; funct7_0 = 0;
    got = 0;
    vcyc = -1;
    for (k = 1; k <= lat + 4; k++) begin
      @(negedge clk);
      if (md_valid === 1'b1) begin
        got = 1;
        vcyc = cyc;
        break;
      end
      if (stall !== 1'b1) st_ok = 0;
    end
    check({name, " latency"}, got ? 32'(k) : 32'hDEAD, 32'(lat));
    check({name, " stall"}, {31'b0, st_ok}, 32'd1);
    if (got) check({name, " stall@done"}, {31'b0, stall}, 32'd0);
    else exp_q.delete();
  endtask

  task automatic abort_div(input bit use_reset, input logic [31:0] held);
    bit st_ok;
    @(posedge clk); #1;
    valid_in = 1; ALUOp = 2'b10; funct7_0 = 1; funct3 = 3'b100;
    op_a = -32'sd20; op_b = 32'd3;
    @(negedge clk);
    st_ok = (stall === 1'b1);
    @(posedge clk); #1;
    valid_in = 0; funct7_0 = 0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (stall !== 1'b1) st_ok = 0;
    end
    @(posedge clk); #1;
    if (use_reset) reset = 1; else flush = 1;
    @(negedge clk);
    if (stall !== 1'b1) st_ok = 0;
    @(posedge clk); #1;
    reset = 0; flush = 0;
    @(negedge clk);
    check(use_reset ? "rst stall T1-10" : "fl stall T1-10",
          {31'b0, st_ok}, 32'd1);
    check(use_reset ? "rst stall T11" : "fl stall T11",
          {31'b0, stall}, 32'd0);
    check(use_reset ? "rst md_result" : "fl md_result held",
          md_result, use_reset ? 32'd0 : held);
    repeat (40) @(negedge clk);
  endtask

  initial begin
    int v1, v2;
    tbl[0]  = '{2'b00, 3'b000, 1'b0, 4'b0010};
    tbl[1]  = '{2'b00, 3'b111, 1'b1, 4'b0010};
    tbl[2]  = '{2'b00, 3'b010, 1'b0, 4'b0010};
    tbl[3]  = '{2'b01, 3'b000, 1'b0, 4'b0110};
    tbl[4]  = '{2'b01, 3'b001, 1'b1, 4'b0110};
    tbl[5]  = '{2'b01, 3'b010, 1'b0, 4'b0110};
    tbl[6]  = '{2'b01, 3'b011, 1'b0, 4'b0110};
    tbl[7]  = '{2'b01, 3'b100, 1'b0, 4'b1000};
    tbl[8]  = '{2'b01, 3'b101, 1'b1, 4'b1000};
    tbl[9]  = '{2'b01, 3'b110, 1'b0, 4'b1001};
    tbl[10] = '{2'b01, 3'b111, 1'b0, 4'b1001};
    tbl[11] = '{2'b10, 3'b000, 1'b0, 4'b0010};
    tbl[12] = '{2'b10, 3'b000, 1'b1, 4'b0110};
    tbl[13] = '{2'b10, 3'b001, 1'b0, 4'b0111};
    tbl[14] = '{2'b10, 3'b010, 1'b0, 4'b1000};
    tbl[15] = '{2'b10, 3'b011, 1'b0, 4'b1001};
    tbl[16] = '{2'b10, 3'b100, 1'b0, 4'b0011};
    tbl[17] = '{2'b10, 3'b101, 1'b0, 4'b0100};
    tbl[18] = '{2'b10, 3'b101, 1'b1, 4'b0101};
    tbl[19] = '{2'b10, 3'b110, 1'b0, 4'b0001};
    tbl[20] = '{2'b10, 3'b111, 1'b0, 4'b0000};
    tbl[21] = '{2'b11, 3'b000, 1'b0, 4'b0010};
    tbl[22] = '{2'b11, 3'b000, 1'b1, 4'b0010};
    tbl[23] = '{2'b11, 3'b001, 1'b0, 4'b0111};
    tbl[24] = '{2'b11, 3'b010, 1'b1, 4'b1000};
    tbl[25] = '{2'b11, 3'b011, 1'b0, 4'b1001};
    tbl[26] = '{2'b11, 3'b100, 1'b0, 4'b0011};
    tbl[27] = '{2'b11, 3'b101, 1'b0, 4'b0100};
    tbl[28] = '{2'b11, 3'b101, 1'b1, 4'b0101};
    tbl[29] = '{2'b11, 3'b110, 1'b0, 4'b0001};
    tbl[30] = '{2'b11, 3'b111, 1'b1, 4'b0000};
    tbl[31] = '{2'b10, 3'b111, 1'b1, 4'b0000};

    reset = 1; valid_in = 0; flush = 0; ALUOp = 0; funct3 = 0;
    funct7_5 = 0; funct7_0 = 0; op_a = 0; op_b = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset stall", {31'b0, stall}, 32'd0);
    check("reset md_valid", {31'b0, md_valid}, 32'd0);
    check("reset md_result", md_result, 32'd0);
    @(posedge clk); #1;
    reset = 0;

    for (int i = 0; i < 32; i++) begin
      ALUOp = tbl[i].aop;
      funct3 = tbl[i].f3;
      funct7_5 = tbl[i].f75;
      funct7_0 = i[0];
      #2;
      check($sformatf("decode[%0d]", i), {28'b0, Operation},
            {28'b0, tbl[i].op});
    end
    funct7_0 = 0;

`ifdef RV_M_EXT_EN
    run_md("MUL", 3'b000, 32'd7, -32'sd3, 32'hFFFFFFEB, XLEN + 1, v1);
    run_md("MULHU", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF,
           32'hFFFFFFFE, XLEN + 1, v1);
    run_md("MULH", 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF,
           32'h0, XLEN + 1, v1);
    run_md("MULHSU", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF,
           32'hFFFFFFFF, XLEN + 1, v1);
    run_md("DIV", 3'b100, -32'sd20, 32'd3, 32'hFFFFFFFA, XLEN + 1, v1);
    run_md("REM", 3'b110, -32'sd20, 32'd3, 32'hFFFFFFFE, XLEN + 1, v1);
    run_md("DIVU", 3'b101, 32'd100, 32'd7, 32'd14, XLEN + 1, v1);
    run_md("REMU", 3'b111, 32'd100, 32'd7, 32'd2, XLEN + 1, v1);
    run_md("DIVU/0", 3'b101, 32'd5, 32'd0, 32'hFFFFFFFF, 1, v1);
    run_md("REM/0", 3'b110, 32'd5, 32'd0, 32'd5, 1, v1);
    run_md("DIVovf", 3'b100, 32'h80000000, 32'hFFFFFFFF,
           32'h80000000, 1, v1);
    run_md("REMovf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h0, 1, v1);
    run_md("MUL2", 3'b000, 32'd1234, 32'd5678, 32'd7006652, XLEN + 1, v1);
    abort_div(1'b0, 32'd7006652);
    abort_div(1'b1, 32'd0);
    run_md("b2b MUL1", 3'b000, 32'd7, -32'sd3, 32'hFFFFFFEB, XLEN + 1, v1);
    run_md("b2b MUL2", 3'b000, 32'd5, 32'd6, 32'd30, XLEN + 1, v2);
    check("b2b gap", 32'(v2 - v1), 32'(XLEN + 2));
    repeat (4) @(negedge clk);
    check("scoreboard empty", 32'(exp_q.size()), 32'd0);
`else
    @(posedge clk); #1;
    valid_in = 1; ALUOp = 2'b10; funct7_0 = 1; funct3 = 3'b000;
    op_a = 32'd7; op_b = 32'd3;
    @(negedge clk);
    check("off stall", {31'b0, stall}, 32'd0);
    @(posedge clk); #1;
    valid_in = 0; funct7_0 = 0;
    repeat (XLEN + 2) @(negedge clk);
    check("off md_valid", {31'b0, md_valid}, 32'd0);
    check("off md_result", md_result, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
